sha256_job_arbiter: RTL and testbench

Shares one `simplified_sha256` core between `NUM_REQ` independent requesters. Each requester posts a job (message address, output address). The block grants jobs round-robin, latches the job's addresses and pulses the core's `start`. It tracks the core through its `done` handshake, returns a per-requester completion pulse with the measured job duration, and flags hung jobs with a watchdog. It sits between the host-side job sources and the core's `start`/`message_addr`/`output_addr`/`done` pins. It does not touch the memory bus.

---
 rtl/sha256_job_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_sha256_job_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_job_arbiter.sv
// sha256_job_arbiter
// Shares one simplified_sha256 core between NUM_REQ requesters. Jobs are
// granted round-robin, their addresses latched, and the core started. The
// core's done handshake is tracked, the job duration measured, and a hung
// core is flagged with a watchdog.
//
// Ports
//   clk, reset_n       clock, asynchronous active-low reset
//   req                per-requester job request (level, held until ack)
//   req_msg_addr       flattened message addresses, slice i = [16i+15:16i]
//   req_out_addr       flattened output addresses, same slicing
//   ack                one-hot one-cycle completion pulse
//   err                pulses with ack when the job timed out
//   job_cycles         cycles from core_start to done rise, held after ack
//   grant_id           current / last granted requester
//   busy               high whenever the FSM is not idle
//   core_start         start pulse to the core
//   core_message_addr  latched message address of the running job
//   core_output_addr   latched output address of the running job
//   core_done          core's done (high while the core is idle)
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for a request while the core is idle
// START     | core_start asserted for this single cycle
// WAIT_BUSY | waiting for the core to leave idle (done falls)
// WAIT_DONE | waiting for the core to finish (done rises)
// ACK       | completion pulse to the granted requester

module sha256_job_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*16-1:0]  req_msg_addr,
    input  logic [NUM_REQ*16-1:0]  req_out_addr,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   err,
    output logic [15:0]            job_cycles,
    output logic [2:0]             grant_id,
    output logic                   busy,
    output logic                   core_start,
    output logic [15:0]            core_message_addr,
    output logic [15:0]            core_output_addr,
    input  logic                   core_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        ACK
    } state_t;

    localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CYCLES);

    state_t       state, state_nxt;
    logic [2:0]   ptr;
    logic [15:0]  cnt, cnt_nxt, cnt_inc;
    logic         timeout_nxt;
    logic         grant;

    // Requests and addresses widened to the 8-entry maximum so the 3-bit
    // winner index can address them directly.
    logic [7:0]   req_ext;
    logic [15:0]  msg_arr [8];
    logic [15:0]  out_arr [8];

    logic [2:0]   win;
    logic         win_vld;
    logic [2:0]   ptr_nxt;
    logic [NUM_REQ-1:0] ack_onehot;

    always_comb begin
        req_ext = 8'(req);
        for (int i = 0; i < 8; i++) begin
            msg_arr[i] = '0;
            out_arr[i] = '0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            msg_arr[i] = req_msg_addr[16*i +: 16];
            out_arr[i] = req_out_addr[16*i +: 16];
        end
    end

    // Round-robin search: first active request at or above ptr, wrapping.
    always_comb begin
        logic [3:0] idx;
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= 4'(NUM_REQ)) begin
                idx = idx - 4'(NUM_REQ);
            end
            if (!win_vld && req_ext[idx[2:0]]) begin
                win     = idx[2:0];
                win_vld = 1'b1;
            end
        end
    end

    assign ptr_nxt = (win == 3'(NUM_REQ - 1)) ? 3'd0 : win + 3'd1;
    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            ack_onehot[i] = (grant_id == 3'(i));
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        timeout_nxt = 1'b0;
        grant       = 1'b0;
        case (state)
            IDLE: begin
                if (core_done && win_vld) begin
                    grant     = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                cnt_nxt = cnt_inc;
                if (cnt_inc >= TIMEOUT) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = ACK;
                end else if (!core_done) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                cnt_nxt = cnt_inc;
                // A done rise on the timeout cycle still counts as success.
                if (core_done) begin
                    state_nxt = ACK;
                end else if (cnt_inc >= TIMEOUT) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = ACK;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state so they line up with the
    // state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            ptr               <= '0;
            cnt               <= '0;
            ack               <= '0;
            err               <= 1'b0;
            job_cycles        <= '0;
            grant_id          <= '0;
            busy              <= 1'b0;
            core_start        <= 1'b0;
            core_message_addr <= '0;
            core_output_addr  <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            busy       <= (state_nxt != IDLE);
            core_start <= (state_nxt == START);
            ack        <= (state_nxt == ACK) ? ack_onehot : '0;
            err        <= (state_nxt == ACK) && timeout_nxt;
            if (state_nxt == ACK) begin
                job_cycles <= cnt_nxt;
            end
            if (grant) begin
                grant_id          <= win;
                ptr               <= ptr_nxt;
                core_message_addr <= msg_arr[win];
                core_output_addr  <= out_arr[win];
            end
        end
    end

endmodule

// File: tb/tb_sha256_job_arbiter.sv
// Randomized scoreboard bench for sha256_job_arbiter with a behavioural
// core whose done stays low for a chosen number of cycles after start.
module tb_sha256_job_arbiter;

    localparam int N  = 4;
    localparam int TO = 250;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N*16-1:0] req_msg_addr, req_out_addr;
    logic [N-1:0]  ack;
    logic          err;
    logic [15:0]   job_cycles;
    logic [2:0]    grant_id;
    logic          busy, core_start;
    logic [15:0]   core_message_addr, core_output_addr;
    logic          core_done = 1'b1;

    logic [15:0]   msg_a [N];
    logic [15:0]   out_a [N];

    sha256_job_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .req(req),
        .req_msg_addr(req_msg_addr), .req_out_addr(req_out_addr),
        .ack(ack), .err(err), .job_cycles(job_cycles), .grant_id(grant_id),
        .busy(busy), .core_start(core_start),
        .core_message_addr(core_message_addr), .core_output_addr(core_output_addr),
        .core_done(core_done)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_msg_addr[16*i +: 16] = msg_a[i];
            req_out_addr[16*i +: 16] = out_a[i];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Behavioural core: done low for 'lat' cycles after sampling start.
    int fixed_lat = 0;
    int lat_q [$];
    int core_cnt = 0;
    always @(posedge clk) begin
        int l;
        if (core_start) begin
            if (fixed_lat > 0) l = fixed_lat;
            else if ($urandom_range(0, 9) == 0) l = TO + int'($urandom_range(1, 60));
            else l = int'($urandom_range(1, 40));
            lat_q.push_back(l);
            core_done <= 1'b0;
            core_cnt = l - 1;
        end else if (!core_done) begin
            if (core_cnt == 0) core_done <= 1'b1;
            else core_cnt--;
        end
    end

    // Inputs as seen by the DUT at the most recent rising edge.
    logic [N-1:0]    snap_req = '0;
    logic            snap_done = 1'b1;
    logic [N*16-1:0] snap_msg, snap_out;
    always @(posedge clk) begin
        snap_req  = req;
        snap_done = core_done;
        snap_msg  = req_msg_addr;
        snap_out  = req_out_addr;
    end

    typedef struct {
        int          id;
        logic [15:0] msg;
        logic [15:0] out;
    } job_t;

    job_t  exp_q [$];
    int    grant_log [$];
    int    model_ptr = 0;
    int    n_starts = 0;
    int    n_err = 0;
    logic  prev_cs = 1'b0;
    logic [N-1:0] last_ack = '0;

    // Monitor / scoreboard.
    always @(negedge clk) begin
        int   w, l, c;
        logic found;
        job_t j;
        if (!reset_n) begin
            prev_cs = 1'b0;
        end else begin
            if (core_start) begin
                n_starts++;
                chk("start_pulse_width", 32'(prev_cs), 0);
                chk("grant_core_idle", 32'(snap_done), 1);
                found = 1'b0;
                w = 0;
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (model_ptr + k) % N;
                    if (!found && snap_req[i]) begin
                        w = i;
                        found = 1'b1;
                    end
                end
                chk("grant_has_req", 32'(found), 1);
                if (found) begin
                    j.id  = w;
                    j.msg = snap_msg[16*w +: 16];
                    j.out = snap_out[16*w +: 16];
                    chk("grant_id", 32'(grant_id), 32'(w));
                    chk("start_msg_addr", 32'(core_message_addr), 32'(j.msg));
                    chk("start_out_addr", 32'(core_output_addr), 32'(j.out));
                    exp_q.push_back(j);
                    grant_log.push_back(w);
                    model_ptr = (w + 1) % N;
                end
            end
            prev_cs = core_start;
            if (err && ack == '0) chk("err_without_ack", 32'(err), 0);
            if (ack != '0) begin
                last_ack = ack;
                if (err) n_err++;
                chk("ack_expected", 32'(exp_q.size() > 0), 1);
                chk("lat_known", 32'(lat_q.size() > 0), 1);
                if (exp_q.size() > 0 && lat_q.size() > 0) begin
                    j = exp_q.pop_front();
                    l = lat_q.pop_front();
                    c = (l + 1 > TO) ? TO : l + 1;
                    chk("ack_onehot", 32'(ack), 32'(1) << j.id);
                    chk("ack_grant_id", 32'(grant_id), 32'(j.id));
                    chk("job_cycles", 32'(job_cycles), 32'(c));
                    chk("err", 32'(err), 32'(l + 1 > TO));
                    chk("ack_msg_addr_stable", 32'(core_message_addr), 32'(j.msg));
                    chk("ack_out_addr_stable", 32'(core_output_addr), 32'(j.out));
                end
            end
        end
    end

    logic [N-1:0] just_acked = '0;

    task automatic tick();
        @(negedge clk);
        just_acked = ack;
        req = req & ~ack;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((req != '0 || !core_done || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(n < budget), 1);
        repeat (3) tick();
    endtask

    task automatic check_reset_vals(input string p);
        chk({p, "_ack"}, 32'(ack), 0);
        chk({p, "_err"}, 32'(err), 0);
        chk({p, "_job_cycles"}, 32'(job_cycles), 0);
        chk({p, "_grant_id"}, 32'(grant_id), 0);
        chk({p, "_busy"}, 32'(busy), 0);
        chk({p, "_core_start"}, 32'(core_start), 0);
        chk({p, "_msg_addr"}, 32'(core_message_addr), 0);
        chk({p, "_out_addr"}, 32'(core_output_addr), 0);
    endtask

    task automatic single_job(input string name, input int id, input int lat,
                              input logic [15:0] m, input logic [15:0] o);
        fixed_lat = lat;
        msg_a[id] = m;
        out_a[id] = o;
        req[id]   = 1'b1;
        drain(name, lat + 100);
    endtask

    initial begin
        int s0, e0, n;
        int exp_order [6] = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < N; i++) begin
            msg_a[i] = 16'(i * 16'h1111);
            out_a[i] = 16'(16'h8000 + i);
        end

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset_n = 1'b1;
        repeat (2) tick();

        // Single job with a 200-cycle core.
        s0 = n_starts;
        single_job("single_drain", 2, 200, 16'h0000, 16'h0100);
        chk("single_starts", 32'(n_starts - s0), 1);
        chk("single_ack", 32'(last_ack), 32'b0100);
        chk("single_job_cycles_held", 32'(job_cycles), 201);
        chk("single_busy_after", 32'(busy), 0);

        // Watchdog boundaries.
        e0 = n_err;
        single_job("bound_below", 0, TO - 1, 16'h1234, 16'h4321);
        chk("bound_below_err", 32'(n_err - e0), 0);
        chk("bound_below_cycles", 32'(job_cycles), TO);
        single_job("bound_at", 1, TO, 16'h2222, 16'h3333);
        chk("bound_at_err", 32'(n_err - e0), 1);

        // Hung core with another requester waiting.
        e0 = n_err;
        s0 = n_starts;
        fixed_lat = TO + 100;
        req[1] = 1'b1;
        n = 0;
        while (n_starts == s0 && n < 50) begin tick(); n++; end
        chk("hang_started", 32'(n < 50), 1);
        tick();
        fixed_lat = 10;
        msg_a[3] = 16'hABCD;
        out_a[3] = 16'hDCBA;
        req[3] = 1'b1;
        drain("hang_drain", 2 * TO + 200);
        chk("hang_err_count", 32'(n_err - e0), 1);
        chk("hang_jobs", 32'(n_starts - s0), 2);

        // Reset in WAIT_DONE.
        s0 = n_starts;
        fixed_lat = 200;
        req[1] = 1'b1;
        n = 0;
        while (n_starts == s0 && n < 50) begin tick(); n++; end
        repeat (20) tick();
        reset_n = 1'b0;
        req = '0;
        #1;
        check_reset_vals("midreset");
        exp_q.delete();
        lat_q.delete();
        model_ptr = 0;
        n = 0;
        while (!core_done && n < 400) begin tick(); n++; end
        chk("midreset_core_idle", 32'(core_done), 1);
        reset_n = 1'b1;
        tick();

        // Round-robin with all requesters continuously re-asserting.
        grant_log.delete();
        fixed_lat = 5;
        req = '1;
        n = 0;
        while (grant_log.size() < 6 && n < 2000) begin
            tick();
            for (int i = 0; i < N; i++)
                if (!req[i] && !just_acked[i]) req[i] = 1'b1;
            n++;
        end
        chk("rr_grants", 32'(grant_log.size() >= 6), 1);
        if (grant_log.size() >= 6)
            for (int k = 0; k < 6; k++)
                chk($sformatf("rr_order_%0d", k), 32'(grant_log[k]), 32'(exp_order[k]));
        drain("rr_drain", 500);

        // Random traffic, random core latency, addresses changing under load.
        fixed_lat = 0;
        n = 0;
        for (int cyc = 0; cyc < 20000 && n < 60; cyc++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (!req[i] && !just_acked[i] && $urandom_range(0, 7) == 0 && n < 60) begin
                    msg_a[i] = 16'($urandom);
                    out_a[i] = 16'($urandom);
                    req[i] = 1'b1;
                    n++;
                end else if (req[i] && $urandom_range(0, 15) == 0) begin
                    msg_a[i] = 16'($urandom);
                    out_a[i] = 16'($urandom);
                end
            end
        end
        drain("random_drain", 30000);
        chk("final_busy", 32'(busy), 0);
        chk("final_queue_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
